// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word requests under a credit limit, in-order response capture
// into a prefetch FIFO, and redirect flush that discards stale in-flight responses.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        srst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          run;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] tag_wr, tag_rd;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   tag_mem   [DEPTH];

  logic          req_fire;
  logic          pop;
  logic          rsp_keep;
  logic          push;
  logic [CW:0]   credit_used;
  logic [CW-1:0] out_next;

  // Credit covers both buffered words and requests whose words are still coming back.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = run & (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign pop      = instr_valid & instr_ready;
  assign rsp_keep = imem_rsp_valid & (drop == '0);
  assign push     = rsp_keep & ~redirect;
  assign out_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign instr_valid = (count != '0);
  assign instr       = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= out_next;
      if (redirect) begin
        // Everything accepted so far, including this cycle's request, is now stale.
        fetch_pc <= redirect_pc & ~32'h3;
        count    <= '0;
        drop     <= out_next;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        tag_wr   <= '0;
        tag_rd   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_wr   <= tag_wr + PW'(1);
        end
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
        if (rsp_keep) tag_rd <= tag_rd + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= tag_mem[tag_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && !redirect) tag_mem[tag_wr] <= fetch_pc;
  end

  assert property (@(posedge clk) disable iff (srst) !(push && count == DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with per-request latency, and a delivery
// model that expects a contiguous PC stream restarting at each redirect target.
module tb_fetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PAT      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        srst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .srst(srst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  mreq_t       memq[$];
  logic [31:0] got_pc[$];
  int          lat;
  int          cyc;
  logic [31:0] exp_pc, exp_req;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: account for this cycle's handshakes, cross the edge, then drive memory.
  task automatic tick();
    logic        acc, pop, rsp, rdr;
    logic [31:0] rpc;
    acc = imem_req_valid && imem_req_ready;
    pop = instr_valid && instr_ready;
    rsp = imem_rsp_valid;
    rdr = redirect;
    rpc = redirect_pc & ~32'h3;
    if (pop) begin
      chk("deliver_pc", instr_pc, exp_pc);
      chk("deliver_instr", instr, exp_pc ^ PAT);
      got_pc.push_back(instr_pc);
      exp_pc += 32'd4;
    end
    if (acc) begin
      chk("req_addr", imem_req_addr, exp_req);
      exp_req += 32'd4;
      memq.push_back('{addr: imem_req_addr, due: cyc + lat});
      chk("outstanding_limit", 32'(memq.size() <= int'(DEPTH)), 32'd1);
    end
    if (rsp) void'(memq.pop_front());
    @(posedge clk);
    cyc++;
    if (rdr) begin
      exp_pc  = rpc;
      exp_req = rpc;
    end
    #1;
    redirect = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr ^ PAT;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (rdr) begin
      chk("redir_instr_valid", 32'(instr_valid), 32'd0);
      chk("redir_req_addr", imem_req_addr, rpc);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    #1;
    srst = 1'b1;
    memq.delete();
    imem_rsp_valid = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    srst    = 1'b0;
    cyc     = 0;
    exp_pc  = RESET_PC;
    exp_req = RESET_PC;
    got_pc.delete();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(got_pc.size() >= n), 32'd1);
  endtask

  initial begin
    vec_t tbl[13];
    int   mark, hits;

    srst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; lat = 1; cyc = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;

    // Stall with instr_ready=0 until the FIFO holds 4, then drain at full rate.
    tbl[0]  = '{1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
    tbl[5]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[6]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[7]  = '{1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[8]  = '{1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
    tbl[9]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
    tbl[10] = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
    tbl[11] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
    tbl[12] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};

    do_reset();
    lat = 1; imem_req_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      instr_ready = tbl[i].rdy;
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), instr, tbl[i].pc ^ PAT);
      end
      tick();
    end

    // 3-cycle memory, two requests in flight, redirect to 0x100.
    do_reset();
    lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (3) tick();
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    run_until(2, 60, "a_deliveries");
    if (got_pc.size() >= 2) begin
      chk("a_first_pc", got_pc[0], 32'h100);
      chk("a_second_pc", got_pc[1], 32'h104);
    end

    // Redirect coinciding with a response and a pop; low redirect bits ignored.
    do_reset();
    lat = 2; imem_req_ready = 1'b1; instr_ready = 1'b0;
    repeat (4) tick();
    chk("b_setup_instr_valid", 32'(instr_valid), 32'd1);
    chk("b_setup_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    run_until(3, 60, "b_deliveries");
    if (got_pc.size() >= 3) begin
      chk("b_popped_pc", got_pc[0], 32'h0);
      chk("b_after_redirect_pc", got_pc[1], 32'h40);
      chk("b_next_pc", got_pc[2], 32'h44);
    end

    // Back-to-back redirects.
    do_reset();
    lat = 2; imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    mark = got_pc.size();
    run_until(mark + 4, 60, "c_deliveries");
    if (got_pc.size() > mark) chk("c_first_pc", got_pc[mark], 32'h300);
    hits = 0;
    for (int i = mark; i < got_pc.size(); i++)
      if (got_pc[i] >= 32'h200 && got_pc[i] < 32'h300) hits++;
    chk("c_no_0x200_stream", 32'(hits), 32'd0);

    // Reset while streaming, then restart from RESET_PC.
    do_reset();
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (7) tick();
    do_reset();
    run_until(2, 40, "d_deliveries");
    if (got_pc.size() >= 1) chk("d_first_pc", got_pc[0], RESET_PC);

    // Randomised traffic, latencies and redirects (some near the top of the address space).
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lat            = int'($urandom_range(1, 4));
      imem_req_ready = ($urandom % 4) != 0;
      instr_ready    = ($urandom % 3) != 0;
      if ($urandom % 40 == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      end
      tick();
    end
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
    mark = got_pc.size();
    run_until(mark + 8, 100, "rand_drain_progress");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle datapath's instruction input. It generates sequential word addresses starting at `RESET_PC`, issues them to instruction memory over a valid/ready request channel, and collects in-order responses. Fetched words go into a `DEPTH`-entry prefetch FIFO, and each `{instr, instr_pc}` pair is handed downstream over a valid/ready handshake. A branch/jump `redirect` flushes all prefetched and in-flight work and restarts fetch at `redirect_pc`.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2. Also the limit on outstanding memory requests.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `srst` in 1: reset, asynchronous, active-high.
- `imem_req_valid` out 1: request address valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response word valid; in order, at most one per cycle, never earlier than the cycle after its acceptance.
- `imem_rsp_data` in 32: fetched instruction.
- `redirect` in 1: one-cycle pulse; flush and restart.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and treated as 0.
- `instr_valid` out 1: FIFO head valid.
- `instr_ready` in 1: downstream consumes the head.
- `instr` out 32: head instruction.
- `instr_pc` out 32: address of the head instruction.

## Operation
- State:
  - `fetch_pc` (32).
  - FIFO storage `{data, pc}` × `DEPTH`, with read/write pointers and `count` (0..`DEPTH`).
  - `outstanding` (0..`DEPTH`): accepted requests not yet answered.
  - `drop` (0..`DEPTH`): responses still to be discarded.
  - `run` flag.
- Reset values:
  - `fetch_pc`=`RESET_PC`; `count`=`outstanding`=`drop`=0; `run`=0.
  - Outputs: `imem_req_valid`=0, `instr_valid`=0, `imem_req_addr`=`RESET_PC`, `instr`=0, `instr_pc`=0.
- `run` sets on the first clock edge after `srst` deasserts and stays 1 until reset.
- Request generation:
  - `imem_req_valid = run & (count + outstanding < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On acceptance (`valid & ready`): `fetch_pc += 4` and `outstanding += 1`. `fetch_pc` wraps modulo 2^32.
- PC tracking: an internal `DEPTH`-entry in-order tag queue records the address of each accepted request, so every response is paired with its PC.
- Response handling, when `imem_rsp_valid`:
  - `outstanding -= 1`.
  - If `drop > 0`: `drop -= 1` and the word is discarded.
  - Otherwise the pair `{imem_rsp_data, tag}` is pushed into the FIFO.
- Credit rule: the credit check guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- Downstream side:
  - `instr_valid = (count != 0)`.
  - `instr`/`instr_pc` show the head entry.
  - The head pops when `instr_valid & instr_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- Redirect has priority over everything else in its cycle:
  - FIFO is emptied: `count`=0 and pointers reset.
  - The tag queue is emptied.
  - `fetch_pc` = `{redirect_pc[31:2], 2'b00}`.
  - `drop` = `outstanding` after this cycle's accept/response updates, so any request accepted in the redirect cycle is counted as stale.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle still counts as delivered: the consumer owns that instruction.
- Back-to-back redirects: each one reloads `drop` from the current `outstanding`, so stale responses are never delivered.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Responses still in flight from memory are the memory's responsibility; `outstanding` restarts at 0.

## Timing
- Fetch latency: a response captured at edge N makes `instr_valid`=1 from edge N onward, i.e. visible in cycle N+1. Minimum request-to-delivery latency is 2 cycles with a 1-cycle memory.
- Throughput: with `imem_req_ready`=1, 1-cycle responses and `instr_ready`=1, the unit sustains one instruction per cycle.
- Redirect: `imem_req_addr` = `redirect_pc` in the cycle after the redirect edge. `instr_valid`=0 in that cycle.
- `imem_req_valid` depends only on registered state. `instr_valid`/`instr`/`instr_pc` are registered-state outputs with no combinational path from `instr_ready`.

## Test plan
- Reset, then release with ready=1 and 1-cycle memory returning `addr ^ 32'hA5A5_0000` → requests 0,4,8,…; `instr_pc` 0,4,8 in order; `instr` matches the pattern; one instruction per cycle after the first 2 cycles.
- `instr_ready`=0 (`DEPTH`=4) → exactly 4 requests accepted, then `imem_req_valid`=0. `count`=4 with no overflow. Releasing `instr_ready` drains 0,4,8,12, then fetch resumes at 16.
- 3-cycle memory latency with 2 requests outstanding, redirect to 0x100 → both stale responses dropped. Next delivered `instr_pc`=0x100, then 0x104.
- Redirect in the same cycle as a response and a pop → the popped instruction is delivered, the response is discarded, and `drop` covers the remaining in-flight request.
- Two redirects on consecutive cycles (0x200, then 0x300) → no instruction from 0x200 is delivered; the first delivered `instr_pc`=0x300.
- `srst` asserted mid-stream, then released → outputs take reset values immediately; fetch restarts at `RESET_PC` and `count`=0.
